// File: rtl/force_wb_arbiter.sv
// rtl/force_wb_arbiter.sv - round-robin force writeback arbiter with local/network steering
package force_wb_pkg;
  localparam int X_DIM     = 4;
  localparam int Y_DIM     = 4;
  localparam int Z_DIM     = 4;
  localparam int NUM_CELLS = X_DIM * Y_DIM * Z_DIM;
  localparam int DEST_W    = 6;

  // Relative neighbour offsets per axis: CELL_1 = -1, CELL_2 = home, CELL_3 = +1
  localparam logic [1:0] CELL_1 = 2'd1;
  localparam logic [1:0] CELL_2 = 2'd2;
  localparam logic [1:0] CELL_3 = 2'd3;

  typedef struct packed {
    logic [1:0] z;
    logic [1:0] y;
    logic [1:0] x;
  } cell_id_t;

  typedef struct packed {
    cell_id_t    cell_id;
    logic [7:0]  particle_id;
    logic [31:0] force_val;
  } force_wb_t;

  typedef struct packed {
    logic [DEST_W-1:0] dest_id;
    logic [7:0]        particle_id;
    logic [31:0]       force_val;
  } packet_t;
endpackage

module cell_to_dest_id_map
  import force_wb_pkg::*;
#(
  parameter int HOME_CELL_ID = 0,
  parameter int HOME_X       = 1,
  parameter int HOME_Y       = 1,
  parameter int HOME_Z       = 1
) (
  input  force_wb_t wb_i,
  output packet_t   pkt_o
);
  localparam int XY = X_DIM * Y_DIM;
  // Per-axis steps expressed modulo NUM_CELLS so a plain wrapping add handles torus wrap
  localparam logic [DEST_W-1:0] HOME_ID = DEST_W'(HOME_CELL_ID);
  localparam logic [DEST_W-1:0] DXP = DEST_W'((HOME_X == X_DIM) ? NUM_CELLS - (X_DIM - 1) : 1);
  localparam logic [DEST_W-1:0] DXM = DEST_W'((HOME_X == 1) ? X_DIM - 1 : NUM_CELLS - 1);
  localparam logic [DEST_W-1:0] DYP = DEST_W'((HOME_Y == Y_DIM) ? NUM_CELLS - X_DIM * (Y_DIM - 1) : X_DIM);
  localparam logic [DEST_W-1:0] DYM = DEST_W'((HOME_Y == 1) ? X_DIM * (Y_DIM - 1) : NUM_CELLS - X_DIM);
  localparam logic [DEST_W-1:0] DZP = DEST_W'((HOME_Z == Z_DIM) ? NUM_CELLS - XY * (Z_DIM - 1) : XY);
  localparam logic [DEST_W-1:0] DZM = DEST_W'((HOME_Z == 1) ? XY * (Z_DIM - 1) : NUM_CELLS - XY);

  function automatic logic [DEST_W-1:0] axis_delta(input logic [1:0] off,
                                                   input logic [DEST_W-1:0] plus,
                                                   input logic [DEST_W-1:0] minus);
    case (off)
      CELL_1:  return minus;
      CELL_3:  return plus;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    pkt_o             = '0;
    pkt_o.dest_id     = HOME_ID + axis_delta(wb_i.cell_id.x, DXP, DXM)
                                + axis_delta(wb_i.cell_id.y, DYP, DYM)
                                + axis_delta(wb_i.cell_id.z, DZP, DZM);
    pkt_o.particle_id = wb_i.particle_id;
    pkt_o.force_val   = wb_i.force_val;
  end
endmodule

module force_wb_arbiter
  import force_wb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOME_CELL_ID = 0,
  parameter int HOME_X       = 1,
  parameter int HOME_Y       = 1,
  parameter int HOME_Z       = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 phase_start,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  force_wb_t            req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 pkt_valid,
  output packet_t              pkt_out,
  input  logic                 pkt_ready,
  output logic                 local_valid,
  output force_wb_t            local_data,
  input  logic                 local_ready,
  output logic                 phase_done,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] local_count,
  output logic                 bad_cell
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   last_seen_q, last_seen_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 stage_valid_q, stage_valid_d;
  logic                 stage_local_q, stage_local_d;
  force_wb_t            stage_data_q, stage_data_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0] local_cnt_q, local_cnt_d;
  logic                 bad_q, bad_d;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_found;
  logic [PW-1:0]      grant_idx;
  int                 cand;
  logic               pkt_hs, local_hs, stage_free, accept;
  logic               sel_local, sel_net, sel_last;
  force_wb_t          sel_data;
  packet_t            map_pkt;

  cell_to_dest_id_map #(
    .HOME_CELL_ID(HOME_CELL_ID),
    .HOME_X      (HOME_X),
    .HOME_Y      (HOME_Y),
    .HOME_Z      (HOME_Z)
  ) u_map (
    .wb_i (stage_data_q),
    .pkt_o(map_pkt)
  );

  assign pkt_valid   = stage_valid_q & ~stage_local_q;
  assign local_valid = stage_valid_q & stage_local_q;
  assign pkt_out     = pkt_valid ? map_pkt : '0;
  assign local_data  = local_valid ? stage_data_q : '0;
  assign pkt_hs      = pkt_valid & pkt_ready;
  assign local_hs    = local_valid & local_ready;
  assign stage_free  = ~stage_valid_q | pkt_hs | local_hs;
  assign phase_done  = (state_q == DONE);
  assign pkt_count   = pkt_cnt_q;
  assign local_count = local_cnt_q;
  assign bad_cell    = bad_q;

  always_comb begin
    eligible    = (state_q == RUN) ? (req_valid & ~last_seen_q) : '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
    accept    = grant_found & stage_free;
    req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // Half-shell neighbours go to the network; anything else but home is dropped
  always_comb begin
    sel_data  = req_data[grant_idx];
    sel_last  = req_last[grant_idx];
    sel_local = (sel_data.cell_id == {CELL_2, CELL_2, CELL_2});
    sel_net   = (sel_data.cell_id.z == CELL_3)
              | (sel_data.cell_id.z == CELL_2 && sel_data.cell_id.y == CELL_3)
              | (sel_data.cell_id == {CELL_2, CELL_2, CELL_3});
  end

  always_comb begin
    state_d       = state_q;
    last_seen_d   = last_seen_q;
    rr_ptr_d      = rr_ptr_q;
    stage_valid_d = stage_valid_q;
    stage_local_d = stage_local_q;
    stage_data_d  = stage_data_q;
    pkt_cnt_d     = pkt_cnt_q;
    local_cnt_d   = local_cnt_q;
    bad_d         = bad_q;

    if (pkt_hs || local_hs) stage_valid_d = 1'b0;
    if (pkt_hs && pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 1'b1;
    if (local_hs && local_cnt_q != '1) local_cnt_d = local_cnt_q + 1'b1;

    if (accept) begin
      rr_ptr_d = grant_idx;
      if (sel_last) last_seen_d[grant_idx] = 1'b1;
      if (sel_local || sel_net) begin
        stage_valid_d = 1'b1;
        stage_local_d = sel_local;
        stage_data_d  = sel_data;
      end else begin
        bad_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: if (phase_start) begin
        state_d     = RUN;
        last_seen_d = '0;
        pkt_cnt_d   = '0;
        local_cnt_d = '0;
        bad_d       = 1'b0;
      end
      RUN:     if (&last_seen_d) state_d = DRAIN;
      DRAIN:   if (!stage_valid_d) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_seen_q   <= '0;
      rr_ptr_q      <= PW'(NUM_REQ - 1);
      stage_valid_q <= 1'b0;
      stage_local_q <= 1'b0;
      stage_data_q  <= '0;
      pkt_cnt_q     <= '0;
      local_cnt_q   <= '0;
      bad_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_seen_q   <= last_seen_d;
      rr_ptr_q      <= rr_ptr_d;
      stage_valid_q <= stage_valid_d;
      stage_local_q <= stage_local_d;
      stage_data_q  <= stage_data_d;
      pkt_cnt_q     <= pkt_cnt_d;
      local_cnt_q   <= local_cnt_d;
      bad_q         <= bad_d;
    end
  end
endmodule

// File: tb/tb_force_wb_arbiter.sv
// tb/tb_force_wb_arbiter.sv - directed self-checking bench for force_wb_arbiter
module tb_force_wb_arbiter;
  import force_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        phase_start = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  force_wb_t   req_data [4];
  logic [3:0]  req_ready;
  logic        pkt_valid;
  packet_t     pkt_out;
  logic        pkt_ready = 1'b0;
  logic        local_valid;
  force_wb_t   local_data;
  logic        local_ready = 1'b0;
  logic        phase_done;
  logic [15:0] pkt_count;
  logic [15:0] local_count;
  logic        bad_cell;

  logic        w_phase_start = 1'b0;
  logic [3:0]  w_req_valid = '0;
  logic [3:0]  w_req_last = '1;
  force_wb_t   w_req_data [4];
  logic [3:0]  w_req_ready;
  logic        w_pkt_valid;
  packet_t     w_pkt_out;
  logic        w_local_valid;
  force_wb_t   w_local_data;
  logic        w_phase_done;
  logic [15:0] w_pkt_count;
  logic [15:0] w_local_count;
  logic        w_bad_cell;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  force_wb_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .phase_start(phase_start),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .pkt_valid(pkt_valid), .pkt_out(pkt_out), .pkt_ready(pkt_ready),
    .local_valid(local_valid), .local_data(local_data), .local_ready(local_ready),
    .phase_done(phase_done), .pkt_count(pkt_count), .local_count(local_count),
    .bad_cell(bad_cell)
  );

  force_wb_arbiter #(.HOME_CELL_ID(X_DIM - 1), .HOME_X(X_DIM)) u_wrap (
    .clk(clk), .rst_n(rst_n), .phase_start(w_phase_start),
    .req_valid(w_req_valid), .req_last(w_req_last), .req_data(w_req_data), .req_ready(w_req_ready),
    .pkt_valid(w_pkt_valid), .pkt_out(w_pkt_out), .pkt_ready(1'b1),
    .local_valid(w_local_valid), .local_data(w_local_data), .local_ready(1'b1),
    .phase_done(w_phase_done), .pkt_count(w_pkt_count), .local_count(w_local_count),
    .bad_cell(w_bad_cell)
  );

  function automatic force_wb_t mk(input logic [1:0] z, input logic [1:0] y, input logic [1:0] x,
                                   input logic [7:0] pid, input logic [31:0] f);
    force_wb_t r;
    r.cell_id.z = z; r.cell_id.y = y; r.cell_id.x = x;
    r.particle_id = pid; r.force_val = f;
    return r;
  endfunction

  function automatic packet_t mkpkt(input logic [5:0] d, input logic [7:0] pid, input logic [31:0] f);
    packet_t p;
    p.dest_id = d; p.particle_id = pid; p.force_val = f;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    phase_start = 1'b0; req_valid = '0; req_last = '0;
    pkt_ready = 1'b0; local_ready = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i] = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_phase();
    phase_start = 1'b1;
    tick();
    phase_start = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if ({pkt_valid, local_valid, phase_done, bad_cell} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {pkt_valid, local_valid, phase_done, bad_cell}); end
    checks++; if ({pkt_count, local_count} !== 32'h0) begin errors++; $display("FAIL reset_counts: got %h expected 0", {pkt_count, local_count}); end
    checks++; if (pkt_out !== '0 || local_data !== '0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0", pkt_out, local_data); end
  endtask

  task automatic test_round_robin();
    int sent [4];
    int g;
    logic [7:0] exp_pid;
    apply_reset();
    pkt_ready = 1'b1;
    start_phase();
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0; req_valid[i] = 1'b1; req_last[i] = 1'b0;
      req_data[i] = mk(CELL_3, CELL_2, CELL_2, 8'(i * 4), 32'(i));
    end
    for (int c = 0; c < 14; c++) begin
      #1;
      if (c < 12) begin
        checks++; if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_grant c%0d: got %b expected %b", c, req_ready, 4'(1 << (c % 4))); end
      end else begin
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rr_no_grant c%0d: got %b expected 0000", c, req_ready); end
      end
      if (c >= 1 && c <= 12) begin
        exp_pid = 8'(((c - 1) % 4) * 4 + (c - 1) / 4);
        checks++; if (pkt_valid !== 1'b1 || pkt_out.particle_id !== exp_pid) begin errors++; $display("FAIL rr_pkt c%0d: got v=%b pid=%0d expected v=1 pid=%0d", c, pkt_valid, pkt_out.particle_id, exp_pid); end
      end
      if (c == 1) begin
        checks++; if (pkt_out.dest_id !== 6'd16) begin errors++; $display("FAIL rr_dest: got %0d expected 16", pkt_out.dest_id); end
      end
      if (c == 12) begin
        checks++; if (phase_done !== 1'b0) begin errors++; $display("FAIL rr_done_early: got %b expected 0", phase_done); end
      end
      if (c == 13) begin
        checks++; if (phase_done !== 1'b1) begin errors++; $display("FAIL rr_done: got %b expected 1", phase_done); end
        checks++; if (pkt_count !== 16'd12 || pkt_valid !== 1'b0) begin errors++; $display("FAIL rr_count: got cnt=%0d v=%b expected cnt=12 v=0", pkt_count, pkt_valid); end
      end
      tick();
      if (c < 12) begin
        g = c % 4;
        sent[g]++;
        req_data[g] = mk(CELL_3, CELL_2, CELL_2, 8'(g * 4 + sent[g]), 32'(g));
        req_last[g] = (sent[g] == 2);
        req_valid[g] = (sent[g] < 3);
      end
    end
    #1;
    checks++; if (phase_done !== 1'b0) begin errors++; $display("FAIL rr_done_pulse: got %b expected 0", phase_done); end
  endtask

  task automatic test_local();
    force_wb_t e;
    apply_reset();
    local_ready = 1'b1;
    start_phase();
    e = mk(CELL_2, CELL_2, CELL_2, 8'h5A, 32'hDEAD_BEEF);
    req_data[0] = e; req_valid = 4'b0001; req_last = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL local_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (local_valid !== 1'b1 || pkt_valid !== 1'b0) begin errors++; $display("FAIL local_valid: got lv=%b pv=%b expected lv=1 pv=0", local_valid, pkt_valid); end
    checks++; if (local_data !== e) begin errors++; $display("FAIL local_data: got %h expected %h", local_data, e); end
    tick();
    #1;
    checks++; if (local_count !== 16'd1 || local_valid !== 1'b0) begin errors++; $display("FAIL local_count: got cnt=%0d lv=%b expected cnt=1 lv=0", local_count, local_valid); end
  endtask

  task automatic test_bad_cell();
    apply_reset();
    pkt_ready = 1'b1; local_ready = 1'b1;
    start_phase();
    for (int i = 0; i < 4; i++) req_data[i] = mk(CELL_1, CELL_1, CELL_1, 8'(i), 32'h0);
    req_last = 4'b1111; req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bad_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bad_once: got %b expected 1000", req_ready); end
    checks++; if (bad_cell !== 1'b1 || pkt_valid !== 1'b0 || local_valid !== 1'b0) begin errors++; $display("FAIL bad_flag: got bad=%b pv=%b lv=%b expected 1 0 0", bad_cell, pkt_valid, local_valid); end
    tick(); #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bad_grant0: got %b expected 0001", req_ready); end
    tick(); #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bad_grant1: got %b expected 0010", req_ready); end
    tick(); #1;
    checks++; if (req_ready !== 4'b0000 || phase_done !== 1'b0) begin errors++; $display("FAIL bad_drain: got rdy=%b done=%b expected 0000 0", req_ready, phase_done); end
    tick(); #1;
    checks++; if (phase_done !== 1'b1 || pkt_count !== 16'd0 || local_count !== 16'd0) begin errors++; $display("FAIL bad_done: got done=%b pc=%0d lc=%0d expected 1 0 0", phase_done, pkt_count, local_count); end
    req_valid = '0;
  endtask

  task automatic test_stall();
    packet_t exp1;
    apply_reset();
    start_phase();
    req_data[1] = mk(CELL_3, CELL_3, CELL_1, 8'h11, 32'hAAAA_0001);
    req_data[3] = mk(CELL_3, CELL_2, CELL_2, 8'h33, 32'hAAAA_0003);
    exp1 = mkpkt(6'd23, 8'h11, 32'hAAAA_0001);
    req_valid = 4'b1010; req_last = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_first: got %b expected 0010", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (pkt_valid !== 1'b1 || pkt_out !== exp1) begin errors++; $display("FAIL stall_hold k%0d: got v=%b %h expected v=1 %h", k, pkt_valid, pkt_out, exp1); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready k%0d: got %b expected 0000", k, req_ready); end
      tick();
    end
    pkt_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL stall_release: got %b expected 1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    #1;
    checks++; if (pkt_out !== mkpkt(6'd16, 8'h33, 32'hAAAA_0003) || pkt_count !== 16'd1) begin errors++; $display("FAIL stall_second: got %h cnt=%0d expected pid 33 dest 16 cnt=1", pkt_out, pkt_count); end
  endtask

  task automatic test_reset_drain();
    apply_reset();
    pkt_ready = 1'b1;
    start_phase();
    for (int i = 0; i < 4; i++) req_data[i] = mk(CELL_3, CELL_2, CELL_2, 8'(i), 32'h0);
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << c)) begin errors++; $display("FAIL drain_grant c%0d: got %b expected %b", c, req_ready, 4'(1 << c)); end
      tick();
      req_valid[c] = 1'b0;
    end
    pkt_ready = 1'b0;
    #1;
    checks++; if (pkt_valid !== 1'b1 || pkt_count !== 16'd3) begin errors++; $display("FAIL drain_state: got v=%b cnt=%0d expected v=1 cnt=3", pkt_valid, pkt_count); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({pkt_valid, local_valid, phase_done, bad_cell, req_ready} !== 8'b0) begin errors++; $display("FAIL async_reset_flags: got %b expected 0", {pkt_valid, local_valid, phase_done, bad_cell, req_ready}); end
    checks++; if (pkt_out !== '0 || pkt_count !== 16'd0) begin errors++; $display("FAIL async_reset_data: got %h cnt=%0d expected 0", pkt_out, pkt_count); end
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111; req_last = 4'b0000;
    tick(); #1;
    checks++; if (req_ready !== 4'b0000 || phase_done !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got rdy=%b done=%b expected 0000 0", req_ready, phase_done); end
    start_phase();
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL restart_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (pkt_valid !== 1'b1 || pkt_out.particle_id !== 8'd0) begin errors++; $display("FAIL restart_pkt: got v=%b pid=%0d expected v=1 pid=0", pkt_valid, pkt_out.particle_id); end
  endtask

  task automatic test_dest_wrap();
    logic [5:0] exp_dest;
    exp_dest = 6'((X_DIM - 1 + NUM_CELLS - X_DIM + 1) % NUM_CELLS);
    for (int i = 0; i < 4; i++) w_req_data[i] = mk(CELL_2, CELL_2, CELL_3, 8'h77, 32'h1234_5678);
    w_phase_start = 1'b1;
    tick();
    w_phase_start = 1'b0;
    w_req_valid = 4'b0001;
    #1;
    checks++; if (w_req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant: got %b expected 0001", w_req_ready); end
    tick();
    w_req_valid = 4'b0000;
    #1;
    checks++; if (w_pkt_valid !== 1'b1 || w_pkt_out.dest_id !== exp_dest) begin errors++; $display("FAIL wrap_dest: got v=%b dest=%0d expected v=1 dest=%0d", w_pkt_valid, w_pkt_out.dest_id, exp_dest); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_data[i] = '0;
      w_req_data[i] = '0;
    end
    test_reset();
    test_round_robin();
    test_local();
    test_bad_cell();
    test_stall();
    test_reset_drain();
    test_dest_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
